mem_bus: RTL and testbench

Parametrised, registered memory-mapped interconnect between the picorv32 native memory port and up to 16 peripheral slots. It decodes a 4-bit slot field from the address and drives one-hot slave selects. Slots are either fixed-latency (interconnect-generated ready) or slave-handshaked. Every transaction terminates: unmapped slots and stalled slaves complete with an error word and raise a sticky error flag. It replaces hand-written chip-select/ready/rdata muxing in top-level designs.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/mem_bus.sv | 191 +++++++++++++++++++
 tb/tb_mem_bus.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_bus_pkg                                              |
// | Description : Shared constants for the mem_bus interconnect: FSM      |
// |               state encoding, error cause codes and slot field width. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package mem_bus_pkg;

    // Width of the slot-select field carved out of the master address.
    localparam int C_SLOT_W = 4;

    // Transaction FSM encoding.
    localparam int                C_ST_W      = 2;
    localparam logic [C_ST_W-1:0] C_ST_IDLE   = 2'd0;
    localparam logic [C_ST_W-1:0] C_ST_ACCESS = 2'd1;
    localparam logic [C_ST_W-1:0] C_ST_DONE   = 2'd2;

    // Error cause codes reported on err_cause.
    localparam logic [1:0] C_CAUSE_NONE     = 2'b00;
    localparam logic [1:0] C_CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] C_CAUSE_TIMEOUT  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_bus.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_bus                                                  |
// | Description : Registered memory-mapped interconnect between the       |
// |               picorv32 native memory port and up to 16 slave slots.   |
// |               Decodes a 4-bit slot field, drives one-hot selects,     |
// |               generates ready for fixed-latency slots, times out      |
// |               stalled handshaked slots and keeps a sticky error log.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_bus
    import mem_bus_pkg::*;
#(
    parameter int                    NUM_SLAVES = 5,
    parameter int                    SEL_LSB    = 12,
    parameter logic [NUM_SLAVES-1:0] SYNC_MASK  = {NUM_SLAVES{1'b1}},
    parameter int                    TIMEOUT    = 64,
    parameter logic [31:0]           ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_cs,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic                     err_irq,
    output logic [1:0]               err_cause,
    output logic [31:0]              err_addr,
    input  logic                     err_clr
);

    // The counter only has to reach TIMEOUT-1, so $clog2 bits suffice.
    localparam int                 C_CNT_W    = $clog2(TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

    // Registered state
    logic [C_ST_W-1:0]     r_state;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [NUM_SLAVES-1:0] r_cs;
    logic [31:0]           r_addr;
    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_err_irq;
    logic [1:0]            r_err_cause;
    logic [31:0]           r_err_addr;

    // Combinational decode / completion
    logic [C_SLOT_W-1:0]   w_req_slot;
    logic [NUM_SLAVES-1:0] w_req_cs;
    logic                  w_mapped;
    logic                  w_sync;
    logic                  w_hs_ready;
    logic [31:0]           w_rdata_sel;
    logic                  w_done;
    logic                  w_err;
    logic [1:0]            w_cause;
    logic [31:0]           w_rdata_next;

    assign w_req_slot = m_addr[SEL_LSB +: C_SLOT_W];

    // Slot decoder: slot values at or above NUM_SLAVES select nothing.
    always_comb begin
        w_req_cs = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_req_cs[i] = (w_req_slot == C_SLOT_W'(i));
        end
    end

    // r_cs is one-hot (or zero for an unmapped slot) for the whole ACCESS
    // phase, so it doubles as the latched slot for all per-slot muxing.
    assign w_mapped   = |r_cs;
    assign w_sync     = |(r_cs & SYNC_MASK);
    assign w_hs_ready = |(r_cs & ~SYNC_MASK & s_ready);

    // Read-data mux from the currently selected slot.
    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_rdata_sel = w_rdata_sel | (s_rdata[32*i +: 32] & {32{r_cs[i]}});
        end
    end

    // Completion priority: unmapped, sync at count 1, handshake, timeout.
    always_comb begin
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_cause = C_CAUSE_NONE;
        if (r_state == C_ST_ACCESS) begin
            if (!w_mapped) begin
                w_done  = 1'b1;
                w_err   = 1'b1;
                w_cause = C_CAUSE_UNMAPPED;
            end else if (w_sync) begin
                w_done = (r_cnt == C_CNT_ONE);
            end else if (w_hs_ready) begin
                w_done = 1'b1;
            end else if (r_cnt == C_CNT_LAST) begin
                w_done  = 1'b1;
                w_err   = 1'b1;
                w_cause = C_CAUSE_TIMEOUT;
            end
        end
    end

    assign w_rdata_next = w_err ? ERR_DATA : w_rdata_sel;

    // Transaction FSM with registered select, ready and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
            r_cs    <= '0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (m_valid) begin
                        r_cs    <= w_req_cs;
                        r_cnt   <= '0;
                        r_addr  <= m_addr;
                        r_state <= C_ST_ACCESS;
                    end
                end
                C_ST_ACCESS: begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                    if (w_done) begin
                        r_rdata <= w_rdata_next;
                        r_ready <= 1'b1;
                        r_cs    <= '0;
                        r_state <= C_ST_DONE;
                    end
                end
                C_ST_DONE: begin
                    // m_valid is deliberately ignored here: the master still
                    // holds it high while it consumes the response.
                    r_ready <= 1'b0;
                    r_state <= C_ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_cs    <= '0;
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error log: first error wins, a clear coinciding with a new
    // error still records that error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_irq   <= 1'b0;
            r_err_cause <= C_CAUSE_NONE;
            r_err_addr  <= '0;
        end else if (w_done && w_err) begin
            r_err_irq <= 1'b1;
            if (!r_err_irq || err_clr) begin
                r_err_cause <= w_cause;
                r_err_addr  <= r_addr;
            end
        end else if (err_clr) begin
            r_err_irq   <= 1'b0;
            r_err_cause <= C_CAUSE_NONE;
            r_err_addr  <= '0;
        end
    end

    assign m_ready   = r_ready;
    assign m_rdata   = r_rdata;
    assign s_cs      = r_cs;
    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = w_mapped ? m_wstrb : 4'b0000;
    assign err_irq   = r_err_irq;
    assign err_cause = r_err_cause;
    assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_bus                                               |
// | Description : Self-checking bench for mem_bus: transaction-level      |
// |               reference model, per-cycle compare, directed and        |
// |               randomized traffic.                                      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mem_bus;

    localparam int            NS    = 5;
    localparam int            SEL   = 12;
    localparam int            TO    = 8;
    localparam logic [NS-1:0] SMASK = 5'b01111;
    localparam logic [31:0]   ERRD  = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_addr;
    logic [31:0]      m_wdata;
    logic [3:0]       m_wstrb;
    logic [31:0]      m_rdata;
    logic [NS-1:0]    s_cs;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic [32*NS-1:0] s_rdata;
    logic [NS-1:0]    s_ready;
    logic             err_irq;
    logic [1:0]       err_cause;
    logic [31:0]      err_addr;
    logic             err_clr;

    always #5 clk = ~clk;

    mem_bus #(
        .NUM_SLAVES (NS),
        .SEL_LSB    (SEL),
        .SYNC_MASK  (SMASK),
        .TIMEOUT    (TO),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .s_cs      (s_cs),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_irq   (err_irq),
        .err_cause (err_cause),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what every output must show in the current cycle.
    bit            chk_en = 1'b0;
    logic          exp_ready;
    logic [NS-1:0] exp_cs;
    logic [3:0]    exp_wstrb;
    logic [31:0]   exp_rdata;
    logic          exp_irq;
    logic [1:0]    exp_cause;
    logic [31:0]   exp_eaddr;
    logic          prev_clr;
    logic          prev_rst;
    logic [31:0]   slot_data [NS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready",   32'(m_ready),   32'(exp_ready));
            chk("m_rdata",   m_rdata,        exp_rdata);
            chk("s_cs",      32'(s_cs),      32'(exp_cs));
            chk("s_wstrb",   32'(s_wstrb),   32'(exp_wstrb));
            chk("s_addr",    s_addr,         m_addr);
            chk("s_wdata",   s_wdata,        m_wdata);
            chk("err_irq",   32'(err_irq),   32'(exp_irq));
            chk("err_cause", 32'(err_cause), 32'(exp_cause));
            chk("err_addr",  err_addr,       exp_eaddr);
        end
    end

    // Advance one clock and apply the edge's effect to the model, using the
    // inputs that were presented during the previous cycle.
    task automatic tick(input bit done, input bit is_err, input logic [1:0] cause,
                        input logic [31:0] eaddr, input logic [31:0] data);
        @(posedge clk);
        #1;
        if (prev_rst) begin
            exp_rdata = '0;
            exp_irq   = 1'b0;
            exp_cause = 2'b00;
            exp_eaddr = '0;
        end else begin
            if (done) exp_rdata = data;
            if (done && is_err) begin
                if (!exp_irq || prev_clr) begin
                    exp_cause = cause;
                    exp_eaddr = eaddr;
                end
                exp_irq = 1'b1;
            end else if (prev_clr) begin
                exp_irq   = 1'b0;
                exp_cause = 2'b00;
                exp_eaddr = '0;
            end
        end
    endtask

    task automatic drive_slots();
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = slot_data[i];
    endtask

    task automatic idle(input int n, input bit clr, input bit noise);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            m_valid   = 1'b0;
            err_clr   = clr && (i == 0);
            s_ready   = noise ? NS'($urandom()) : '0;
            exp_ready = 1'b0;
            exp_cs    = '0;
            exp_wstrb = 4'b0000;
            prev_clr  = err_clr;
            prev_rst  = rst;
        end
    endtask

    // One master transaction, starting in the cycle after the call.
    // rdy_cycle: cycle the handshaked slave raises s_ready (<1 or >TO: never)
    // clr_cycle: cycle err_clr is pulsed (directed mode)
    // rst_cycle: cycle rst is pulsed to abort the access (-1: none)
    // obs:       cycle the DUT was seen raising m_ready (-1: never)
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] strb,
                           input int rdy_cycle, input int clr_cycle,
                           input int rst_cycle, input bit noise, output int obs);
        int            slot;
        bit            mapped;
        bit            sync;
        bit            is_err;
        int            resp;
        logic [1:0]    cause;
        logic [31:0]   data;
        logic [NS-1:0] onehot;
        logic [15:0]   smask16;
        logic [31:0]   wdata;

        smask16 = 16'(SMASK);
        slot    = int'(addr[SEL +: 4]);
        mapped  = (slot < NS);
        sync    = mapped && smask16[slot];
        onehot  = mapped ? NS'(1 << slot) : '0;
        wdata   = $urandom();
        obs     = -1;

        if (!mapped) begin
            resp = 2; is_err = 1'b1; cause = 2'b01; data = ERRD;
        end else if (sync) begin
            resp = 3; is_err = 1'b0; cause = 2'b00; data = slot_data[slot];
        end else if (rdy_cycle >= 1 && rdy_cycle <= TO) begin
            resp = rdy_cycle + 1; is_err = 1'b0; cause = 2'b00; data = slot_data[slot];
        end else begin
            resp = TO + 1; is_err = 1'b1; cause = 2'b10; data = ERRD;
        end

        for (int c = 0; c <= resp; c++) begin
            if (rst_cycle >= 0 && c == rst_cycle + 1) begin
                tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                rst       = 1'b0;
                m_valid   = 1'b0;
                s_ready   = '0;
                err_clr   = 1'b0;
                exp_ready = 1'b0;
                exp_cs    = '0;
                exp_wstrb = 4'b0000;
                prev_clr  = 1'b0;
                prev_rst  = 1'b0;
                if (m_ready) obs = c;
                break;
            end
            tick(c == resp, is_err, cause, addr, data);
            if (m_ready && obs < 0) obs = c;
            m_valid = 1'b1;
            m_addr  = addr;
            m_wstrb = strb;
            m_wdata = wdata;
            drive_slots();
            s_ready = noise ? NS'($urandom()) : '0;
            if (mapped && !sync) s_ready[slot] = (c == rdy_cycle);
            err_clr   = noise ? ($urandom_range(0, 7) == 0) : (c == clr_cycle);
            rst       = (c == rst_cycle);
            exp_ready = (c == resp);
            exp_cs    = (c >= 1 && c < resp) ? onehot : '0;
            exp_wstrb = (exp_cs != '0) ? strb : 4'b0000;
            prev_clr  = err_clr;
            prev_rst  = rst;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs;
        int slot;
        int gap;
        logic [31:0] addr;

        rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_rdata = '0; s_ready = '0; err_clr = 1'b0;
        prev_clr = 1'b0; prev_rst = 1'b1;
        exp_ready = 1'b0; exp_cs = '0; exp_wstrb = '0; exp_rdata = '0;
        exp_irq = 1'b0; exp_cause = 2'b00; exp_eaddr = '0;
        for (int i = 0; i < NS; i++) slot_data[i] = '0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            rst = (i < 1);
            exp_ready = 1'b0; exp_cs = '0; exp_wstrb = '0;
            prev_clr = 1'b0; prev_rst = rst;
            chk_en = 1'b1;
        end
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_err_irq", 32'(err_irq), 32'h0);
        chk("rst_s_cs",    32'(s_cs), 32'h0);

        // Sync read of slot 1
        slot_data[1] = 32'h1234_5678;
        run_txn(32'h0000_1004, 4'b0000, -1, -1, -1, 1'b0, obs);
        chk("sync_latency", 32'(obs), 32'd3);
        chk("sync_rdata", m_rdata, 32'h1234_5678);
        idle(1, 1'b0, 1'b0);

        // Handshaked write to slot 4, ready in cycle 5
        run_txn(32'h0000_4000, 4'b0001, 5, -1, -1, 1'b0, obs);
        chk("hs_latency", 32'(obs), 32'd6);
        chk("hs_err_irq", 32'(err_irq), 32'h0);
        idle(1, 1'b0, 1'b0);

        // Unmapped read
        run_txn(32'h0000_9000, 4'b0000, -1, -1, -1, 1'b0, obs);
        chk("unm_latency", 32'(obs), 32'd2);
        chk("unm_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("unm_irq", 32'(err_irq), 32'h1);
        chk("unm_cause", 32'(err_cause), 32'h1);
        chk("unm_addr", err_addr, 32'h0000_9000);
        idle(2, 1'b1, 1'b0);
        chk("clr_irq", 32'(err_irq), 32'h0);

        // Timeout then unmapped
        run_txn(32'h0000_4000, 4'b0000, -1, -1, -1, 1'b0, obs);
        chk("to_latency", 32'(obs), 32'd9);
        chk("to_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("to_cause", 32'(err_cause), 32'h2);
        idle(1, 1'b0, 1'b0);
        run_txn(32'h0000_A000, 4'b0000, -1, -1, -1, 1'b0, obs);
        chk("sticky_cause", 32'(err_cause), 32'h2);
        chk("sticky_addr", err_addr, 32'h0000_4000);
        idle(2, 1'b1, 1'b0);
        chk("clr2_irq", 32'(err_irq), 32'h0);
        chk("clr2_cause", 32'(err_cause), 32'h0);
        chk("clr2_addr", err_addr, 32'h0);

        // Error/clear collision
        run_txn(32'h0000_F000, 4'b0000, -1, -1, -1, 1'b0, obs);
        idle(1, 1'b0, 1'b0);
        run_txn(32'h0000_5000, 4'b0000, -1, 1, -1, 1'b0, obs);
        chk("coll_irq", 32'(err_irq), 32'h1);
        chk("coll_cause", 32'(err_cause), 32'h1);
        chk("coll_addr", err_addr, 32'h0000_5000);
        idle(1, 1'b0, 1'b0);

        // Reset mid-access, then a fresh sync read
        run_txn(32'h0000_4000, 4'b0000, -1, -1, 3, 1'b0, obs);
        chk("rst_abort_cs", 32'(s_cs), 32'h0);
        chk("rst_abort_ready", 32'(m_ready), 32'h0);
        chk("rst_abort_noresp", 32'(obs), 32'hFFFF_FFFF);
        slot_data[2] = 32'hCAFE_0002;
        run_txn(32'h0000_2008, 4'b0000, -1, -1, -1, 1'b0, obs);
        chk("post_rst_latency", 32'(obs), 32'd3);
        chk("post_rst_rdata", m_rdata, 32'hCAFE_0002);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            for (int i = 0; i < NS; i++) slot_data[i] = $urandom();
            slot = $urandom_range(0, 7);
            addr = $urandom();
            addr[SEL +: 4] = 4'(slot);
            run_txn(addr, 4'($urandom()), $urandom_range(1, TO + 2), -1,
                    ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1,
                    1'b1, obs);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap, 1'b0, 1'b1);
        end
        idle(2, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
